// File: rtl/floor_request_queue_if.sv
// Elevator-facing bundle of the floor request queue.
// master = queue side (drives head request/status), slave = elevator side.
interface floor_request_queue_if #(
    parameter int NUM_FLOORS = 4
);
    localparam int CW = $clog2(NUM_FLOORS) + 1;

    logic                  arr_valid;
    logic [NUM_FLOORS-1:0] arr_floor;
    logic [NUM_FLOORS-1:0] F;
    logic                  en;
    logic [NUM_FLOORS-1:0] pending;
    logic [CW-1:0]         count;
    logic                  err;

    modport master (
        input  arr_valid, arr_floor,
        output F, en, pending, count, err
    );

    modport slave (
        output arr_valid, arr_floor,
        input  F, en, pending, count, err
    );
endinterface

// File: rtl/floor_request_queue.sv
// Call button conditioner + arrival-order floor request queue.
// Define FLOOR_REQ_DEBOUNCE_EN to include the per-button debounce counters.
module floor_request_queue #(
    parameter int NUM_FLOORS      = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_raw,
    input  logic                  run_raw_n,
    floor_request_queue_if.master bus
);
    localparam int N  = NUM_FLOORS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N) + 1;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [N-1:0] call_s1, call_s2;
    logic [N-1:0] level, level_d;
    logic         run_s1, run_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            call_s1 <= '0;
            call_s2 <= '0;
            run_s1  <= 1'b1;
            run_s2  <= 1'b1;
            level_d <= '0;
        end else begin
            call_s1 <= call_raw;
            call_s2 <= call_s1;
            run_s1  <= run_raw_n;
            run_s2  <= run_s1;
            level_d <= level;
        end
    end

`ifdef FLOOR_REQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] db_cnt [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int i = 0; i < N; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (call_s2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]  <= call_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign level = call_s2;
`endif

    logic [IW-1:0] q [N];
    logic [IW-1:0] q_n [N];
    logic [IW-1:0] head, head_n, tail, tail_n;
    logic [CW-1:0] count, count_n;
    logic [N-1:0]  pending, pending_n;
    logic [N-1:0]  ev, head_oh;
    logic          err, arr_oh, pop, empty;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ev      = level & ~level_d;
    assign empty   = (count == '0);
    assign head_oh = empty ? '0 : (N'(1) << q[head]);
    assign arr_oh  = (bus.arr_floor != '0) &&
                     ((bus.arr_floor & (bus.arr_floor - 1'b1)) == '0);
    assign pop     = bus.arr_valid && arr_oh && !empty &&
                     (bus.arr_floor == head_oh);

    // Pop clears the head's pending bit first, so a same-cycle call re-enqueues it.
    always_comb begin
        q_n       = q;
        head_n    = head;
        tail_n    = tail;
        count_n   = count;
        pending_n = pending;
        if (pop) begin
            pending_n[q[head]] = 1'b0;
            head_n             = ptr_inc(head);
            count_n            = count - 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (ev[i] && !pending_n[i]) begin
                q_n[tail_n]  = IW'(i);
                tail_n       = ptr_inc(tail_n);
                pending_n[i] = 1'b1;
                count_n      = count_n + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) q[i] <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pending <= '0;
            err     <= 1'b0;
        end else begin
            q       <= q_n;
            head    <= head_n;
            tail    <= tail_n;
            count   <= count_n;
            pending <= pending_n;
            if (bus.arr_valid && !arr_oh) err <= 1'b1;
        end
    end

    assign bus.F       = head_oh;
    assign bus.en      = !run_s2 && !empty;
    assign bus.pending = pending;
    assign bus.count   = count;
    assign bus.err     = err;
endmodule

// File: tb/tb_floor_request_queue.sv
// Randomised bench for floor_request_queue against a list-based queue model.
// Works with or without FLOOR_REQ_DEBOUNCE_EN (call latency adapts).
`timescale 1ns/1ps
module tb_floor_request_queue;
    localparam int N = 4;
    localparam int D = 4;
`ifdef FLOOR_REQ_DEBOUNCE_EN
    localparam int LAT = 3 + D;
`else
    localparam int LAT = 3;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] call_raw;
    logic         run_raw_n;

    floor_request_queue_if #(.NUM_FLOORS(N)) bus ();

    floor_request_queue #(
        .NUM_FLOORS(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .call_raw(call_raw),
        .run_raw_n(run_raw_n),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int mq[$];
    bit merr;
    bit run_on;
    int n_pass;
    int n_checks;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit in_q(int f);
        foreach (mq[i]) if (mq[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] m_pending();
        logic [N-1:0] p = '0;
        foreach (mq[i]) p[mq[i]] = 1'b1;
        return p;
    endfunction

    function automatic logic [N-1:0] m_head();
        logic [N-1:0] h = '0;
        if (mq.size() > 0) h[mq[0]] = 1'b1;
        return h;
    endfunction

    // One clock of queue behaviour: arrival first, then new calls low to high.
    function automatic void m_step(bit av, logic [N-1:0] af,
                                   logic [N-1:0] ev);
        if (av) begin
            if ($countones(af) != 1) merr = 1'b1;
            else if (mq.size() > 0 && af == m_head()) void'(mq.pop_front());
        end
        for (int i = 0; i < N; i++)
            if (ev[i] && !in_q(i)) mq.push_back(i);
    endfunction

    task automatic check_all(string tag);
        check({tag, ".F"},       32'(bus.F),       32'(m_head()));
        check({tag, ".pending"}, 32'(bus.pending), 32'(m_pending()));
        check({tag, ".count"},   32'(bus.count),   32'(mq.size()));
        check({tag, ".en"},      32'(bus.en),
              32'(run_on && mq.size() > 0));
        check({tag, ".err"},     32'(bus.err),     32'(merr));
    endtask

    task automatic arrive(logic [N-1:0] f, string tag);
        @(negedge clk);
        bus.arr_valid = 1'b1;
        bus.arr_floor = f;
        @(negedge clk);
        bus.arr_valid = 1'b0;
        bus.arr_floor = '0;
        m_step(1'b1, f, '0);
        check_all(tag);
    endtask

    task automatic press(logic [N-1:0] mask, bit with_pop, string tag);
        bit av;
        logic [N-1:0] af;
        @(negedge clk);
        call_raw = call_raw | mask;
        repeat (LAT - 1) @(negedge clk);
        check_all({tag, ".early"});
        av = with_pop && mq.size() > 0;
        af = av ? m_head() : '0;
        bus.arr_valid = av;
        bus.arr_floor = af;
        @(negedge clk);
        bus.arr_valid = 1'b0;
        bus.arr_floor = '0;
        m_step(av, af, mask);
        check_all(tag);
        call_raw = call_raw & ~mask;
        repeat (LAT + 2) @(negedge clk);
        check_all({tag, ".rel"});
    endtask

    task automatic set_run(bit v);
        @(negedge clk);
        run_raw_n = v;
        @(negedge clk);
        check_all("run.early");
        @(negedge clk);
        run_on = !v;
        check_all("run");
    endtask

    initial begin
        n_pass        = 0;
        n_checks      = 0;
        merr          = 1'b0;
        run_on        = 1'b0;
        rst_n         = 1'b0;
        call_raw      = '0;
        run_raw_n     = 1'b1;
        bus.arr_valid = 1'b0;
        bus.arr_floor = '0;
        #25;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        set_run(1'b0);
        press(4'b0100, 1'b0, "press2");
        check("press2.F_const", 32'(bus.F), 32'h4);
        arrive(4'b0100, "pop2");

        press(4'b1000, 1'b0, "p3");
        press(4'b0001, 1'b0, "p0");
        press(4'b1000, 1'b0, "p3dup");
        press(4'b0010, 1'b0, "p1");
        check("order.count_const", 32'(bus.count), 32'd3);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        run_on = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_on = 1'b1;
        check_all("rst_release");

        for (int k = 0; k < 5; k++) begin
            call_raw[1] = ~call_raw[1];
            repeat (2) @(negedge clk);
        end
        repeat (LAT + 2) @(negedge clk);
        m_step(1'b0, '0, 4'b0010);
        check_all("bounce");
        call_raw[1] = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check_all("bounce.rel");
        arrive(4'b0010, "pop1");

        press(4'b0101, 1'b0, "same_cycle");
        check("same_cycle.F_const", 32'(bus.F), 32'h1);
        arrive(4'b0001, "pop0");
        press(4'b0010, 1'b0, "q21");
        arrive(4'b0010, "nonhead");
        arrive(4'b0100, "pophead");
        check("pophead.F_const", 32'(bus.F), 32'h2);
        press(4'b0010, 1'b1, "pop_reenq");
        check("pop_reenq.count_const", 32'(bus.count), 32'd1);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 4))
                0: press(4'($urandom_range(1, 15)), 1'b0, "rnd_press");
                1: press(4'($urandom_range(1, 15)), 1'b1, "rnd_press_pop");
                2: arrive((mq.size() > 0) ? m_head()
                          : 4'(4'b0001 << $urandom_range(0, 3)), "rnd_head");
                3: arrive(4'(4'b0001 << $urandom_range(0, 3)), "rnd_arr");
                default: set_run(1'($urandom_range(0, 1)));
            endcase
        end

        press(4'b1000, 1'b0, "pre_err");
        arrive(4'b0110, "err_multi");
        check("err.const", 32'(bus.err), 32'd1);
        arrive(m_head(), "err_sticky");
        arrive(4'b0000, "err_zero");
        set_run(1'b0);
        set_run(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
